// File: rtl/aes256_key_expand.sv
// AES-256 key schedule: loads a 256-bit key, expands one word per clock into 60 words (15 round keys).
// Optional synchronous key zeroization is compiled in with the AES_KEY_ZEROIZE_EN macro.
module aes256_key_expand #(
    parameter int unsigned NUM_RK = 15,
    parameter int unsigned NK     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_data,
    output logic         busy,
    output logic         keys_valid
`ifdef AES_KEY_ZEROIZE_EN
    ,
    input  logic         zeroize
`endif
);

    localparam int unsigned NW     = NUM_RK * 4;
    localparam int unsigned IW     = 6;
    localparam logic [IW-1:0] LAST = IW'(NW - 1);

    // S-box table, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} state_t;

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   i;
    logic [31:0]     w [NW];
    logic            zero_c;
    logic            load_c;
    logic            step_c;
    logic [31:0]     prev_c;
    logic [31:0]     sub_in_c;
    logic [31:0]     sub_out_c;
    logic [7:0]      rcon_c;
    logic [31:0]     t_c;
    logic [31:0]     w_new_c;
    logic [IW-1:0]   base_c;

`ifdef AES_KEY_ZEROIZE_EN
    assign zero_c = zeroize;
`else
    assign zero_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Zeroize overrides everything; start is honoured only outside EXPAND.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = EXPAND;
            EXPAND:     if (i == LAST) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
        if (zero_c) state_nx = IDLE;
    end

    always_comb begin
        load_c = 1'b0;
        step_c = 1'b0;
        if (!zero_c) begin
            load_c = start && (state != EXPAND);
            step_c = (state == EXPAND);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            keys_valid <= 1'b0;
        end else begin
            busy       <= (state_nx == EXPAND);
            keys_valid <= (state_nx == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   i <= '0;
        else if (zero_c)              i <= '0;
        else if (load_c)              i <= IW'(NK);
        else if (step_c && i != LAST) i <= i + IW'(1);
    end

    // Next schedule word; only meaningful in EXPAND where 8 <= i <= 59.
    always_comb begin
        prev_c    = w[i - IW'(1)];
        sub_in_c  = (i[2:0] == 3'd0) ? {prev_c[23:0], prev_c[31:24]} : prev_c;
        sub_out_c = {sbox(sub_in_c[31:24]), sbox(sub_in_c[23:16]),
                     sbox(sub_in_c[15:8]),  sbox(sub_in_c[7:0])};
        rcon_c    = 8'(8'h01 << (3'(i[5:3] - 3'd1)));
        case (i[2:0])
            3'd0:    t_c = sub_out_c ^ {rcon_c, 24'h0};
            3'd4:    t_c = sub_out_c;
            default: t_c = prev_c;
        endcase
        w_new_c = w[i - IW'(8)] ^ t_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NW; k++) w[k] <= '0;
        end else if (zero_c) begin
            for (int k = 0; k < NW; k++) w[k] <= '0;
        end else if (load_c) begin
            for (int k = 0; k < NK; k++) w[k] <= key[255 - 32*k -: 32];
        end else if (step_c) begin
            w[i] <= w_new_c;
        end
    end

    // Round-key read port; out-of-range indices return zero.
    always_comb begin
        base_c  = {rk_idx, 2'b00};
        rk_data = '0;
        if (rk_idx < 4'(NUM_RK))
            rk_data = {w[base_c], w[base_c + IW'(1)], w[base_c + IW'(2)], w[base_c + IW'(3)]};
    end

endmodule

// File: tb/tb_aes256_key_expand.sv
// Bench for aes256_key_expand: FIPS-197 vectors through an expected-value queue, plus control corner cases.
module tb_aes256_key_expand;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [255:0] key;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         busy;
    logic         keys_valid;
`ifdef AES_KEY_ZEROIZE_EN
    logic         zeroize;
`endif

    aes256_key_expand dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key        (key),
        .rk_idx     (rk_idx),
        .rk_data    (rk_data),
        .busy       (busy),
        .keys_valid (keys_valid)
`ifdef AES_KEY_ZEROIZE_EN
        ,
        .zeroize    (zeroize)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic [3:0]   idx;
        logic [127:0] mask;
        logic [127:0] value;
    } exp_t;

    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] ALL    = '1;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] idx, input logic [127:0] mask,
                        input logic [127:0] value);
        exp_t e;
        e.tag = tag; e.idx = idx; e.mask = mask; e.value = value;
        sb.push_back(e);
    endtask

    task automatic push_c3(input string pfx);
        push({pfx, "_rk0"},  4'd0,  ALL, 128'h000102030405060708090a0b0c0d0e0f);
        push({pfx, "_rk1"},  4'd1,  ALL, 128'h101112131415161718191a1b1c1d1e1f);
        push({pfx, "_rk2"},  4'd2,  ALL, 128'ha573c29fa176c498a97fce93a572c09c);
        push({pfx, "_rk14"}, 4'd14, ALL, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        push({pfx, "_rk15"}, 4'd15, ALL, 128'h0);
    endtask

    task automatic push_a3(input string pfx);
        push({pfx, "_w8"},  4'd2,  {32'hffffffff, 96'h0}, {32'h9ba35411, 96'h0});
        push({pfx, "_w59"}, 4'd14, {96'h0, 32'hffffffff}, {96'h0, 32'h706c631e});
    endtask

    // Pops every queued expectation and compares it with the addressed round key.
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rk_idx = e.idx;
            #1;
            check(e.tag, rk_data & e.mask, e.value & e.mask);
        end
    endtask

    // Drives a one-cycle start; returns at the negedge after the sampling edge.
    task automatic do_start(input logic [255:0] k);
        @(negedge clk);
        key   = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key   = ~k;
    endtask

    // Counts edges until keys_valid rises (bounded) and compares with the expected count.
    task automatic wait_done(input string tag, input int exp_edges);
        int n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (keys_valid) break;
        end
        check(tag, 128'(n), 128'(exp_edges));
        check({tag, "_busy"}, 128'(busy), 128'(0));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_kv"},   128'(keys_valid), 128'(0));
        for (int r = 0; r < 15; r++) begin
            rk_idx = 4'(r);
            #1;
            check($sformatf("%s_rk%0d", tag, r), rk_data, 128'h0);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        key    = '0;
        rk_idx = '0;
`ifdef AES_KEY_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        #23;
        check_cleared("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Plain FIPS-197 C.3 expansion.
        push_c3("c3");
        do_start(KEY_C3);
        check("c3_busy_on", 128'(busy), 128'(1));
        wait_done("c3_lat", 52);
        drain();

        // Re-key from DONE with A.3; a start at cycle 20 with another key must be ignored.
        push_a3("a3");
        do_start(KEY_A3);
        check("rekey_kv_drop", 128'(keys_valid), 128'(0));
        repeat (20) @(posedge clk);
        do_start(KEY_C3);
        check("ign_busy", 128'(busy), 128'(1));
        wait_done("a3_lat", 31);
        drain();

        // Re-key back to C.3 from DONE.
        push_c3("c3b");
        do_start(KEY_C3);
        check("rekey2_kv_drop", 128'(keys_valid), 128'(0));
        wait_done("c3b_lat", 52);
        drain();

        // Asynchronous reset in the middle of an expansion.
        do_start(KEY_A3);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("midrst");
        @(negedge clk);
        rst_n = 1'b1;

`ifdef AES_KEY_ZEROIZE_EN
        push_c3("zc3");
        do_start(KEY_C3);
        wait_done("zc3_lat", 52);
        drain();
        @(negedge clk);
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        check_cleared("zero");
        @(negedge clk);
        zeroize = 1'b1;
        start   = 1'b1;
        key     = KEY_A3;
        @(negedge clk);
        zeroize = 1'b0;
        start   = 1'b0;
        check("zero_start_busy", 128'(busy), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        check("zero_start_idle", 128'(busy), 128'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
